// File: rtl/sobel_stream_io.sv
// Streaming front end for a BRAM-based Sobel core: loads a frame into the source BRAM,
// kicks the core, then drains the result BRAM through a 2-entry skid FIFO.
module sobel_stream_io #(
    parameter int DATA_WIDTH   = 8,
    parameter int ADDR_WIDTH   = 16,
    parameter int IMAGE_WIDTH  = 100,
    parameter int IMAGE_HEIGHT = 100
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_start,
    input  logic                  s_valid,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  s_ready,
    output logic                  o_run,
    output logic [ADDR_WIDTH-1:0] o_num_cnt,
    input  logic                  i_done,
    output logic                  b0_ce0,
    output logic                  b0_we0,
    output logic [ADDR_WIDTH-1:0] b0_addr0,
    output logic [DATA_WIDTH-1:0] b0_d0,
    output logic                  b1_ce0,
    output logic                  b1_we0,
    output logic [ADDR_WIDTH-1:0] b1_addr0,
    output logic [DATA_WIDTH-1:0] b1_d0,
    input  logic [DATA_WIDTH-1:0] b1_q0,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    input  logic                  m_ready,
    output logic                  o_busy,
    output logic                  o_done
);

    localparam int NUM_PIX = IMAGE_WIDTH * IMAGE_HEIGHT;
    // One extra bit so a full 2^ADDR_WIDTH frame still reaches its terminal count.
    localparam logic [ADDR_WIDTH:0] NUM_PIX_C = (ADDR_WIDTH + 1)'(NUM_PIX);
    localparam logic [ADDR_WIDTH:0] LAST_C    = (ADDR_WIDTH + 1)'(NUM_PIX - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_WAIT,
        S_UNLOAD,
        S_DONE
    } state_t;

    state_t state, next_state;

    logic [ADDR_WIDTH:0]  wr_cnt, rd_cnt, out_cnt;
    logic                 load_hs, issue, pop, in_flight;
    logic [1:0]           occ;
    logic                 wr_ptr, rd_ptr;
    logic [DATA_WIDTH-1:0] fifo_mem [2];
    logic [2:0]           pending;

    assign o_num_cnt = NUM_PIX_C[ADDR_WIDTH-1:0];

    assign load_hs = s_valid && (state == S_LOAD);
    assign m_valid = (occ != 2'd0);
    assign m_data  = m_valid ? fifo_mem[rd_ptr] : '0;
    assign m_last  = m_valid && (out_cnt == LAST_C);
    assign pop     = m_valid && m_ready;

    // Entries the FIFO will hold after this cycle if no new read is issued.
    assign pending = {1'b0, occ} + {2'b00, in_flight} - {2'b00, pop};
    assign issue   = (state == S_UNLOAD) && (rd_cnt < NUM_PIX_C) && (pending < 3'd2);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
        next_state = state;
        case (state)
            S_IDLE:   if (i_start) next_state = S_LOAD;
            S_LOAD:   if (load_hs && (wr_cnt == LAST_C)) next_state = S_RUN;
            S_RUN:    next_state = S_WAIT;
            S_WAIT:   if (i_done) next_state = S_UNLOAD;
            S_UNLOAD: if (pop && m_last) next_state = S_DONE;
            S_DONE:   next_state = S_IDLE;
            default:  next_state = S_IDLE;
        endcase
    end

    always_comb begin
        s_ready  = (state == S_LOAD);
        o_run    = (state == S_RUN);
        o_done   = (state == S_DONE);
        o_busy   = (state != S_IDLE);
        b0_ce0   = load_hs;
        b0_we0   = load_hs;
        b0_addr0 = load_hs ? wr_cnt[ADDR_WIDTH-1:0] : '0;
        b0_d0    = load_hs ? s_data : '0;
        b1_ce0   = issue;
        b1_we0   = 1'b0;
        b1_addr0 = issue ? rd_cnt[ADDR_WIDTH-1:0] : '0;
        b1_d0    = '0;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_cnt    <= '0;
            rd_cnt    <= '0;
            out_cnt   <= '0;
            in_flight <= 1'b0;
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            occ       <= 2'd0;
        end else if ((state == S_IDLE) && i_start) begin
            wr_cnt    <= '0;
            rd_cnt    <= '0;
            out_cnt   <= '0;
            in_flight <= 1'b0;
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            occ       <= 2'd0;
        end else begin
            if (load_hs) wr_cnt <= wr_cnt + 1'b1;
            if (issue)   rd_cnt <= rd_cnt + 1'b1;
            in_flight <= issue;
            if (in_flight) wr_ptr <= ~wr_ptr;
            if (pop) begin
                rd_ptr  <= ~rd_ptr;
                out_cnt <= out_cnt + 1'b1;
            end
            occ <= occ + {1'b0, in_flight} - {1'b0, pop};
        end
    end

    // NOTE: FIFO storage is not reset; occupancy and pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (in_flight) fifo_mem[wr_ptr] <= b1_q0;
    end

endmodule

// File: tb/tb_sobel_stream_io.sv
// Scoreboard bench for sobel_stream_io on a 4x4 frame: BRAM models, expected-queue
// monitor for b0 writes and the output stream, plus directed protocol checks.
module tb_sobel_stream_io;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_start, s_valid, s_ready, o_run, i_done;
    logic [7:0]  s_data;
    logic [15:0] o_num_cnt;
    logic        b0_ce0, b0_we0, b1_ce0, b1_we0;
    logic [15:0] b0_addr0, b1_addr0;
    logic [7:0]  b0_d0, b1_d0, b1_q0;
    logic        m_valid, m_last, m_ready, o_busy, o_done;
    logic [7:0]  m_data;

    sobel_stream_io #(
        .DATA_WIDTH(8), .ADDR_WIDTH(16), .IMAGE_WIDTH(4), .IMAGE_HEIGHT(4)
    ) dut (
        .clk(clk), .rst(rst), .i_start(i_start),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .o_run(o_run), .o_num_cnt(o_num_cnt), .i_done(i_done),
        .b0_ce0(b0_ce0), .b0_we0(b0_we0), .b0_addr0(b0_addr0), .b0_d0(b0_d0),
        .b1_ce0(b1_ce0), .b1_we0(b1_we0), .b1_addr0(b1_addr0), .b1_d0(b1_d0),
        .b1_q0(b1_q0),
        .m_valid(m_valid), .m_data(m_data), .m_last(m_last), .m_ready(m_ready),
        .o_busy(o_busy), .o_done(o_done)
    );

    always #5 clk = ~clk;

    logic [7:0] b1_mem [16];
    always @(posedge clk) if (b1_ce0) b1_q0 <= b1_mem[b1_addr0[3:0]];

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_wa[$];
    logic [7:0]  exp_wd[$];
    logic [7:0]  exp_d[$];
    logic        exp_l[$];
    int run_cnt = 0, run_exp = 0;
    int issued = 0, popped = 0, pix_seen = 0;
    bit bp_en = 1'b0;
    bit stall_prev = 1'b0;
    logic [7:0] held;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Downstream ready: always 1, or a coin flip per cycle during the backpressure frame.
    initial begin
        m_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1 m_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: pops expected writes/pixels whenever the DUT presents them.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                issued = 0;
                popped = 0;
                stall_prev = 1'b0;
            end else begin
                if (b0_ce0) begin
                    if (exp_wa.size() == 0) begin
                        check("b0_unexpected_ce", b0_ce0, 0);
                    end else begin
                        check("b0_addr", b0_addr0, exp_wa.pop_front());
                        check("b0_data", b0_d0, exp_wd.pop_front());
                        check("b0_we", b0_we0, 1);
                    end
                end else begin
                    check("bus0_quiet", {b0_we0, b0_addr0, b0_d0}, 0);
                end
                if (b1_ce0) begin
                    issued++;
                    check("b1_we_d_zero", {b1_we0, b1_d0}, 0);
                end else begin
                    check("bus1_quiet", {b1_we0, b1_addr0, b1_d0}, 0);
                end
                if (o_run) run_cnt++;
                if (stall_prev) begin
                    check("stall_valid", m_valid, 1);
                    check("stall_data", m_data, held);
                end
                if (m_valid && m_ready) begin
                    popped++;
                    pix_seen++;
                    if (exp_d.size() == 0) begin
                        check("m_unexpected_valid", m_valid, 0);
                    end else begin
                        check("m_data", m_data, exp_d.pop_front());
                        check("m_last", m_last, exp_l.pop_front());
                    end
                end
                if (b1_ce0) check("outstanding_le2", 64'(issued - popped > 2), 0);
                stall_prev = m_valid && !m_ready;
                held = m_data;
            end
        end
    end

    task automatic load_frame(input logic [7:0] base, input bit gapped);
        i_start = 1'b1;
        @(posedge clk);
        #1 i_start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (gapped && i > 0) begin
                s_valid = 1'b0;
                s_data  = 8'hEE;
                i_done  = (i == 5);
                @(negedge clk);
                check("gap_no_write", b0_ce0, 0);
                check("gap_still_load", s_ready, 1);
                @(posedge clk);
                #1 i_done = 1'b0;
            end
            s_valid = 1'b1;
            s_data  = base + 8'(i);
            exp_wa.push_back(16'(i));
            exp_wd.push_back(base + 8'(i));
            @(negedge clk);
            check("load_ready", s_ready, 1);
            @(posedge clk);
            #1;
        end
        s_valid = 1'b0;
        run_exp++;
        @(negedge clk);
        check("run_pulse", o_run, 1);
        check("ready_low_run", s_ready, 0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("run_once", o_run, 0);
        check("wait_busy", o_busy, 1);
        check("run_count", run_cnt, run_exp);
        check("all_writes_seen", exp_wa.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic fill_b1(input bit variant);
        for (int i = 0; i < 16; i++) begin
            b1_mem[i] = variant ? 8'(200 - i) : 8'(i * 3);
            exp_d.push_back(b1_mem[i]);
            exp_l.push_back(i == 15);
        end
    endtask

    task automatic unload_fast(input bit variant);
        fill_b1(variant);
        pix_seen = 0;
        i_done = 1'b1;
        @(posedge clk);
        #1 i_done = 1'b0;
        @(negedge clk);
        check("first_read_ce", b1_ce0, 1);
        check("first_read_addr", b1_addr0, 0);
        check("lat_valid_c0", m_valid, 0);
        @(negedge clk);
        check("lat_valid_c1", m_valid, 0);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            check("stream_valid", m_valid, 1);
        end
        @(negedge clk);
        check("done_pulse", o_done, 1);
        check("done_no_valid", m_valid, 0);
        @(negedge clk);
        check("done_once", o_done, 0);
        check("idle_not_busy", o_busy, 0);
        check("unload_drained", exp_d.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit got_done;
        rst = 1'b1;
        i_start = 1'b0;
        s_valid = 1'b0;
        s_data = 8'h00;
        i_done = 1'b0;
        #3;
        check("reset_outputs", {s_ready, o_run, b0_ce0, b0_we0, b1_ce0, b1_we0,
                                m_valid, m_last, o_busy, o_done}, 0);
        check("reset_num_cnt", o_num_cnt, 16);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;

        // Contiguous load, spurious i_start in WAIT, full-rate unload.
        load_frame(8'h10, 1'b0);
        i_start = 1'b1;
        @(posedge clk);
        #1 i_start = 1'b0;
        @(negedge clk);
        check("wait_ignores_start", {o_busy, s_ready, o_run, m_valid, b1_ce0}, 5'b10000);
        @(posedge clk);
        #1;
        unload_fast(1'b0);

        // Gapped load with spurious i_done, then random backpressure.
        load_frame(8'h20, 1'b1);
        fill_b1(1'b0);
        bp_en = 1'b1;
        i_done = 1'b1;
        @(posedge clk);
        #1 i_done = 1'b0;
        got_done = 1'b0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (o_done) begin
                got_done = 1'b1;
                break;
            end
        end
        check("bp_done_seen", got_done, 1);
        check("bp_drained", exp_d.size(), 0);
        bp_en = 1'b0;
        @(posedge clk);
        #1;

        // Reset after 5 delivered pixels, then a fresh frame from address 0.
        load_frame(8'h30, 1'b0);
        fill_b1(1'b0);
        pix_seen = 0;
        i_done = 1'b1;
        @(posedge clk);
        #1 i_done = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(posedge clk);
            if (pix_seen >= 5) break;
        end
        #2 rst = 1'b1;
        #1;
        check("rst_pixels_seen", pix_seen, 5);
        check("rst_mid_outputs", {s_ready, o_run, b0_ce0, b0_we0, b1_ce0, b1_we0,
                                  m_valid, m_last, o_busy, o_done}, 0);
        check("rst_mid_num_cnt", o_num_cnt, 16);
        exp_d.delete();
        exp_l.delete();
        @(posedge clk);
        #1;
        @(posedge clk);
        #1 rst = 1'b0;
        load_frame(8'h40, 1'b0);
        unload_fast(1'b1);

        check("final_run_count", run_cnt, 4);
        check("final_wr_queue", exp_wa.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/sobel_stream_io.md
SOBEL_STREAM_IO -- requirements
Module: sobel_stream_io

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, pixel width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 16, BRAM address width.
REQ-003 SHALL have parameter IMAGE_WIDTH, default 100, pixels per line.
REQ-004 SHALL have parameter IMAGE_HEIGHT, default 100, lines per frame; NUM_PIX = IMAGE_WIDTH*IMAGE_HEIGHT, which SHALL be at most 2^ADDR_WIDTH.
REQ-005 SHALL have ports, in this order:
- clk  in  1  sole clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- i_start  in  1  begin frame; sampled in IDLE only.
- s_valid  in  1  input pixel valid.
- s_data  in  DATA_WIDTH  input pixel.
- s_ready  out  1  input pixel accepted when high with s_valid.
- o_run  out  1  one-cycle start pulse to the Sobel core.
- o_num_cnt  out  ADDR_WIDTH  constant NUM_PIX to the Sobel core.
- i_done  in  1  Sobel core completion pulse.
- b0_ce0, b0_we0  out  1  source BRAM port-0 enable and write enable.
- b0_addr0  out  ADDR_WIDTH  source BRAM port-0 address.
- b0_d0  out  DATA_WIDTH  source BRAM port-0 write data.
- b1_ce0, b1_we0  out  1  result BRAM port-0 enable and write enable.
- b1_addr0  out  ADDR_WIDTH  result BRAM port-0 address.
- b1_d0  out  DATA_WIDTH  result BRAM port-0 write data.
- b1_q0  in  DATA_WIDTH  result BRAM read data, valid 1 cycle after ce.
- m_valid  out  1  output pixel valid.
- m_data  out  DATA_WIDTH  output pixel.
- m_last  out  1  marks pixel NUM_PIX-1.
- m_ready  in  1  downstream accept.
- o_busy  out  1  high in every state except IDLE.
- o_done  out  1  one-cycle pulse in DONE.

Function
REQ-006 SHALL implement FSM IDLE -> LOAD -> RUN -> WAIT -> UNLOAD -> DONE -> IDLE.
REQ-007 IDLE: i_start=1 SHALL move to LOAD next cycle and clear wr_cnt and rd_cnt; i_start in any other state SHALL be ignored.
REQ-008 LOAD: s_ready SHALL be 1; on each s_valid&&s_ready, b0_ce0=b0_we0=1, b0_addr0=wr_cnt, b0_d0=s_data in the same cycle (combinational), then wr_cnt increments.
REQ-009 LOAD SHALL exit to RUN on the handshake with wr_cnt=NUM_PIX-1; s_ready SHALL be 0 outside LOAD.
REQ-010 RUN SHALL last exactly one cycle with o_run=1, then go to WAIT.
REQ-011 WAIT SHALL hold until i_done=1, then go to UNLOAD; i_done outside WAIT SHALL be ignored.
REQ-012 UNLOAD SHALL issue a read (b1_ce0=1, b1_addr0=rd_cnt, rd_cnt++) when rd_cnt<NUM_PIX and (occupancy + in_flight - pop_this_cycle) < 2.
REQ-013 Read data SHALL be captured from b1_q0 one cycle after issue into a 2-entry FIFO; m_valid=FIFO non-empty, m_data=head.
REQ-014 With m_ready held 1, the output SHALL sustain one pixel per cycle after 2-cycle initial latency from UNLOAD entry.
REQ-015 m_data and m_valid SHALL stay stable while m_valid&&!m_ready; no pixel SHALL be dropped or duplicated.
REQ-016 m_last SHALL be 1 exactly with pixel index NUM_PIX-1.
REQ-017 The handshake of the m_last pixel SHALL move to DONE; DONE lasts one cycle with o_done=1, then IDLE.
REQ-018 b1_we0 and b1_d0 SHALL be 0 at all times; b0_ce0, b0_we0 SHALL be 0 outside LOAD handshakes; b0 and b1 address/data SHALL be 0 when their ce is 0.
REQ-019 Counters SHALL be ADDR_WIDTH+1 bits so NUM_PIX=2^ADDR_WIDTH terminates without wrap.
REQ-020 o_num_cnt SHALL equal NUM_PIX truncated to ADDR_WIDTH bits at all times, including reset.

Reset
REQ-021 rst=1 SHALL immediately (asynchronously) force IDLE, clear counters and FIFO, and drive s_ready, o_run, all ce/we, m_valid, m_last, o_busy, o_done to 0.
REQ-022 rst asserted mid-LOAD or mid-UNLOAD SHALL discard all progress; the next frame SHALL restart from address 0.

Verification (IMAGE_WIDTH=4, IMAGE_HEIGHT=4, NUM_PIX=16)
REQ-023 Load: i_start, 16 pixels 0x10..0x1F with s_valid always 1 -> b0 writes addr 0..15 in consecutive cycles; o_run is pulsed once, one cycle after the last write.
REQ-024 Gapped load: s_valid toggles 1/0 -> exactly 16 writes, addresses contiguous, no write in s_valid=0 cycles.
REQ-025 Unload: b1 preloaded with addr*3, i_done pulse, m_ready=1 -> m_data 0,3,...,45 on 16 consecutive cycles; m_last on 45; o_done one cycle later.
REQ-026 Backpressure: m_ready random 50% -> identical 16-value sequence; data stable while stalled; never more than 2 reads outstanding beyond consumption.
REQ-027 Reset mid-UNLOAD after 5 pixels -> all outputs 0 same cycle; a new frame re-loads and outputs from pixel 0.
REQ-028 Spurious i_start in WAIT and i_done in LOAD -> no state change.
